// File: rtl/dp_pkg.sv
// Shared types and constants for the compare/add-subtract datapath sequencer.
package dp_pkg;

   localparam int N_A  = 8;
   localparam int AW_A = 3;
   localparam int AW_B = 2;

   localparam logic [AW_A-1:0] LAST_A = AW_A'(N_A - 1);

   localparam logic SEL_ADD = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      LOAD_A = 3'd2,
      LOAD_B = 3'd3,
      EXEC   = 3'd4,
      WRITE  = 3'd5,
      DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/dp_sequencer.sv
// Control FSM for the compare/add-subtract datapath: walks A (and wrapping B),
// picks sum or difference per element from the comparator sign, counts subtractions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// INIT   | clear A/B counters, reset subtraction count
// LOAD_A | load A operand register
// LOAD_B | load B operand register
// EXEC   | comparator sign settles; load result with live sel
// WRITE  | write result at addr_a, advance counters, test last element
// DONE   | one-cycle done pulse
module dp_sequencer
   import dp_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            sign,
   input  logic [AW_A-1:0] addr_a,
   output logic            clr_a,
   output logic            inc_a,
   output logic            clr_b,
   output logic            inc_b,
   output logic            ld_a,
   output logic            ld_b,
   output logic            ld_r,
   output logic            sel,
   output logic            we,
   output logic            busy,
   output logic            done,
   output logic [3:0]      sub_cnt
);

   state_t state, state_nxt;
   logic   sign_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = INIT;
         INIT:    state_nxt = LOAD_A;
         LOAD_A:  state_nxt = LOAD_B;
         LOAD_B:  state_nxt = EXEC;
         EXEC:    state_nxt = WRITE;
         // addr_a is still the pre-increment index here
         WRITE:   state_nxt = (addr_a == LAST_A) ? DONE : LOAD_A;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clr_a = 1'b0;
      inc_a = 1'b0;
      clr_b = 1'b0;
      inc_b = 1'b0;
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      ld_r  = 1'b0;
      sel   = SEL_ADD;
      we    = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         INIT: begin
            clr_a = 1'b1;
            clr_b = 1'b1;
            busy  = 1'b1;
         end
         LOAD_A: begin
            ld_a = 1'b1;
            busy = 1'b1;
         end
         LOAD_B: begin
            ld_b = 1'b1;
            busy = 1'b1;
         end
         EXEC: begin
            ld_r = 1'b1;
            sel  = sign ? SEL_SUB : SEL_ADD;
            busy = 1'b1;
         end
         WRITE: begin
            we    = 1'b1;
            inc_a = 1'b1;
            inc_b = 1'b1;
            sel   = sign_q ? SEL_SUB : SEL_ADD;
            busy  = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // sign_q holds the EXEC decision so sel stays stable through WRITE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sign_q  <= 1'b0;
         sub_cnt <= 4'd0;
      end else begin
         if (state == INIT) begin
            sub_cnt <= 4'd0;
         end else if (state == EXEC && sign && sub_cnt != 4'hf) begin
            sub_cnt <= sub_cnt + 4'd1;
         end
         if (state == EXEC) begin
            sign_q <= sign;
         end
      end
   end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: per-cycle strobe pattern, sub_cnt, resets, held start.
module tb_dp_sequencer;
   import dp_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            sign;
   logic [AW_A-1:0] addr_a;
   logic            clr_a, inc_a, clr_b, inc_b, ld_a, ld_b, ld_r, sel, we, busy, done;
   logic [3:0]      sub_cnt;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  we_cnt  = 0;
   bit  alt     = 1'b0;
   logic [AW_A-1:0] a_cnt = '0;

   logic [10:0] obs_vec;
   assign obs_vec = {clr_a, inc_a, clr_b, inc_b, ld_a, ld_b, ld_r, sel, we, busy, done};

   // A-counter model standing in for the datapath; comparator sign set on even elements when alt
   always @(posedge clk) begin
      if (clr_a)      a_cnt <= '0;
      else if (inc_a) a_cnt <= a_cnt + 1'b1;
   end
   assign addr_a = a_cnt;
   assign sign   = alt & ~a_cnt[0];

   always #5 clk = ~clk;

   dp_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .sign    (sign),
      .addr_a  (addr_a),
      .clr_a   (clr_a),
      .inc_a   (inc_a),
      .clr_b   (clr_b),
      .inc_b   (inc_b),
      .ld_a    (ld_a),
      .ld_b    (ld_b),
      .ld_r    (ld_r),
      .sel     (sel),
      .we      (we),
      .busy    (busy),
      .done    (done),
      .sub_cnt (sub_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected strobes for cycle r of a run (r=1 is INIT, r=34 is DONE)
   function automatic logic [10:0] exp_vec(input int r, input bit alt_i);
      logic c_a, i_a, c_b, i_b, l_a, l_b, l_r, s, w, b, d;
      int p, e;
      {c_a, i_a, c_b, i_b, l_a, l_b, l_r, s, w, b, d} = '0;
      if (r == 1) begin
         c_a = 1'b1; c_b = 1'b1; b = 1'b1;
      end else if (r >= 2 && r <= 33) begin
         p = (r - 2) % 4;
         e = (r - 2) / 4;
         b = 1'b1;
         case (p)
            0: l_a = 1'b1;
            1: l_b = 1'b1;
            2: begin l_r = 1'b1; s = alt_i && (e % 2 == 0); end
            default: begin w = 1'b1; i_a = 1'b1; i_b = 1'b1; s = alt_i && (e % 2 == 0); end
         endcase
      end else if (r == 34) begin
         d = 1'b1;
      end
      return {c_a, i_a, c_b, i_b, l_a, l_b, l_r, s, w, b, d};
   endfunction

   // Called at a negedge in IDLE; start is dropped at cycle 'hold'
   task automatic run(input int n, input int hold, input bit alt_i);
      int r;
      alt    = alt_i;
      start  = 1'b1;
      we_cnt = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (c >= hold) start = 1'b0;
         r = (c <= 35) ? c : c - 35;
         chk($sformatf("strobes_c%0d", c), 16'(obs_vec), 16'(exp_vec(r, alt_i)));
         if (we) begin
            chk($sformatf("we_addr_c%0d", c), 16'(addr_a), 16'((r - 5) / 4));
            we_cnt++;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_reset_outputs", 16'(obs_vec), 16'h0);
      chk("in_reset_sub_cnt", 16'(sub_cnt), 16'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_release_outputs", 16'(obs_vec), 16'h0);

      // Full run, sign tied low
      run(34, 1, 1'b0);
      chk("run0_sub_cnt", 16'(sub_cnt), 16'd0);
      chk("run0_we_count", 16'(we_cnt), 16'd8);
      @(negedge clk);
      chk("run0_idle", 16'(obs_vec), 16'h0);

      // Alternating sign
      run(34, 1, 1'b1);
      chk("run1_sub_cnt", 16'(sub_cnt), 16'd4);
      chk("run1_we_count", 16'(we_cnt), 16'd8);
      @(negedge clk);
      chk("run1_sub_cnt_hold", 16'(sub_cnt), 16'd4);

      // Async reset mid-cycle, checked before the next clock edge
      #2 reset = 1'b0;
      #1;
      chk("async_outputs", 16'(obs_vec), 16'h0);
      chk("async_sub_cnt", 16'(sub_cnt), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("async_release_outputs", 16'(obs_vec), 16'h0);

      // Start held high: DONE at 34, IDLE at 35, INIT at 36; stop in EXEC of element 3
      run(51, 40, 1'b1);
      chk("held_sub_cnt_elem3", 16'(sub_cnt), 16'd2);

      // Reset during EXEC of element 3
      #2 reset = 1'b0;
      #1;
      chk("midrun_outputs", 16'(obs_vec), 16'h0);
      chk("midrun_sub_cnt", 16'(sub_cnt), 16'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("midrun_quiet_%0d", k), 16'({we, done, busy}), 16'h0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("midrun_release_outputs", 16'(obs_vec), 16'h0);

      // Fresh run after the abandoned one
      run(34, 1, 1'b0);
      chk("fresh_sub_cnt", 16'(sub_cnt), 16'd0);
      chk("fresh_we_count", 16'(we_cnt), 16'd8);
      @(negedge clk);
      chk("fresh_idle", 16'(obs_vec), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Control FSM directly upstream of the compare/add-subtract datapath.
- Walks operand memory A (8 entries, 3-bit counter) and operand memory B (4 entries, 2-bit counter, wraps).
- For each A element: loads the A and B operand registers, samples the comparator sign, then selects sum or difference into the result register and writes it back.
- Start/busy/done handshake toward the top-level; also counts how many subtractions were chosen.

Parameters:
- N_A, 8, number of A elements per run; last index is N_A-1.
- AW_A, 3, width of A address.
- AW_B, 2, width of B address; B index wraps modulo 2^AW_B.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset: reset=0 forces reset immediately, regardless of clk.
- start  in  1  request a run; sampled only in IDLE.
- sign  in  1  comparator output: 1 when A operand < B operand.
- addr_a  in  AW_A  current A counter value from the datapath.
- clr_a  out  1  synchronous clear of A counter.
- inc_a  out  1  increment A counter.
- clr_b  out  1  synchronous clear of B counter.
- inc_b  out  1  increment B counter.
- ld_a  out  1  load A operand register.
- ld_b  out  1  load B operand register.
- ld_r  out  1  load result register.
- sel  out  1  mux select: 1 = difference, 0 = sum.
- we  out  1  result write strobe at addr_a.
- busy  out  1  high from INIT through WRITE of the last element.
- done  out  1  one-cycle pulse at end of run.
- sub_cnt  out  4  number of elements in the last/current run where sel=1.

Behaviour:
- States: IDLE, INIT, LOAD_A, LOAD_B, EXEC, WRITE, DONE. Outputs are Moore-decoded from state, except sel in EXEC (see below).
- Reset (reset=0, async): state=IDLE, sign_q=0, sub_cnt=0. All strobes, busy and done are 0 while reset is asserted and in the first cycle after release.
- Reset mid-run: abandons the run immediately; no done pulse; sub_cnt returns to 0.
- IDLE: all strobes 0. start=1 -> INIT.
- INIT: clr_a=1, clr_b=1, busy=1, sub_cnt<=0 -> LOAD_A.
- LOAD_A: ld_a=1 -> LOAD_B.
- LOAD_B: ld_b=1 -> EXEC.
- EXEC:
  - ld_r=1.
  - sel=sign (live; operand registers are stable).
  - sign_q<=sign.
  - if sign=1, sub_cnt<=sub_cnt+1 (saturates at 15, unreachable for N_A=8).
  - -> WRITE.
- WRITE:
  - we=1, inc_a=1, inc_b=1, sel=sign_q.
  - Last-element test uses the pre-increment addr_a: addr_a==N_A-1 -> DONE; else -> LOAD_A.
- DONE: done=1, busy=0 -> IDLE. sub_cnt holds its value until the next INIT.
- Latency: start sampled at edge 0 -> INIT in cycle 1 -> 4 cycles per element -> DONE in cycle 2+4*N_A (cycle 34 for N_A=8).
- A new start may be accepted in the cycle after DONE.
- start while busy or in DONE: ignored, not queued.
- B index wrap: inc_b at addr_b=3 yields 0. The controller does not inspect addr_b. Element i therefore pairs A[i] with B[i mod 4].
- Counters are required to honour inc (increment only when inc=1); clr has priority over inc.
- Only one of ld_a/ld_b/ld_r/we is ever high in a cycle; inc_a and inc_b are high only in WRITE.
- addr_a is sampled only in WRITE, so a glitch on addr_a in other states has no effect.

Decomposition:
- Shared package dp_pkg holds:
  - state enum (IDLE=0 … DONE=6, 3-bit encoding);
  - constants N_A, AW_A, AW_B;
  - SEL_ADD=0, SEL_SUB=1.
- No sub-module needed: single FSM plus sign_q and sub_cnt registers.
- The 4-bit saturating counter may be factored as sat_counter4 if reused.

Test Plan:
- Reset: assert reset=0 asynchronously mid-cycle -> state IDLE and all outputs 0 before the next clk edge; sub_cnt=0.
- Full run, sign tied 0:
  - start pulse at edge 0 -> clr_a/clr_b in cycle 1.
  - ld_a, ld_b, ld_r, we pattern repeats 8 times.
  - done=1 in cycle 34 only; sub_cnt=0; busy high for cycles 1–33.
- Alternating sign (1 on even elements) -> sel=1 during EXEC and WRITE of elements 0, 2, 4, 6; sub_cnt=4 at done.
- Termination check: drive addr_a from a model counter -> exactly 8 we pulses, addresses 0..7; the WRITE at addr_a=7 goes to DONE.
- start held high for 40 cycles -> first run completes at cycle 34; second INIT at cycle 36 (IDLE in cycle 35 samples start). No start accepted during busy.
- Reset mid-run: reset=0 during EXEC of element 3 -> no done, no further we; after release, start -> fresh run from INIT with sub_cnt=0.
